dma_p0_packer: RTL and testbench

Write-back receiver on the DMA side of the engine's port-0 output stream. Accepts the 16-bit result words the engine emits one per cycle under `dma_p0_writes_en`. Packs them into `16*BURST_LEN`-bit lines, queues them in a small line FIFO, and issues masked, address-sequenced write commands to the memory interface. A flush at layer end pushes out any partial line and reports completion.

---
 rtl/dma_p0_packer.sv | 242 ++++++++++++++++++++++++
 tb/tb_dma_p0_packer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_p0_packer.sv
// ---------------------------------------------------------------------------
// dma_p0_packer
//
// Write-back receiver for the engine's port-0 result stream. 16-bit words
// arrive one per cycle (no backpressure toward the engine), are packed into
// 16*BURST_LEN-bit lines, queued in a small line FIFO and presented to the
// memory side as masked, address-sequenced write commands. A flush at layer
// end pushes out any partial line and pulses flush_done once everything
// queued has been accepted by the memory side.
//
// Ports
//   clk, rst_n        : single rising-edge clock, asynchronous active-low reset
//   start             : one-cycle pulse, begins a layer at base_addr
//   base_addr         : byte address of the first line (line aligned)
//   dma_p0_writes_en  : dma_p0_ib_data carries a valid word this cycle
//   dma_p0_ib_data    : 16-bit result word
//   flush             : one-cycle pulse, the layer is finished
//   wr_cmd_valid/ready: write command handshake toward memory
//   wr_cmd_addr       : byte address of the line
//   wr_cmd_data       : packed line, word k in [16k+:16]
//   wr_cmd_mask       : bit k set when word k is valid
//   busy              : layer in progress (start .. flush_done)
//   flush_done        : one-cycle pulse when the flush has drained
//   overflow          : sticky error (dropped line or word outside a layer)
//   word_count        : words accepted since start, wraps at 2^32
// ---------------------------------------------------------------------------
module dma_p0_packer #(
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 30,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     dma_p0_writes_en,
    input  logic [15:0]              dma_p0_ib_data,
    input  logic                     flush,
    output logic                     wr_cmd_valid,
    input  logic                     wr_cmd_ready,
    output logic [ADDR_W-1:0]        wr_cmd_addr,
    output logic [16*BURST_LEN-1:0]  wr_cmd_data,
    output logic [BURST_LEN-1:0]     wr_cmd_mask,
    output logic                     busy,
    output logic                     flush_done,
    output logic                     overflow,
    output logic [31:0]              word_count
);

    localparam int LINE_W = 16 * BURST_LEN;
    localparam int LANE_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int PTR_W  = $clog2(DEPTH);

    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(2 * BURST_LEN);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Packer state
    logic [BURST_LEN-1:0][15:0] pack_lanes;
    logic [LANE_W-1:0]          lane_idx;
    logic [ADDR_W-1:0]          cur_addr;

    // Line FIFO
    logic [ADDR_W-1:0]    fifo_addr [DEPTH];
    logic [LINE_W-1:0]    fifo_data [DEPTH];
    logic [BURST_LEN-1:0] fifo_mask [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       fifo_count;

    // Per-cycle decisions
    logic                       word_accept;
    logic                       stray_word;
    logic                       line_complete;
    logic                       partial_push;
    logic                       push_req;
    logic                       push_ok;
    logic                       push_drop;
    logic                       pop;
    logic                       fifo_full;
    logic [BURST_LEN-1:0][15:0] line_data;
    logic [BURST_LEN-1:0]       line_mask;

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. start restarts a layer from any state, including
    // mid-drain; whatever was still queued is abandoned.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_IDLE:  state_next = ST_IDLE;
                ST_RUN:   if (flush) state_next = ST_FLUSH;
                ST_FLUSH: state_next = ST_DRAIN;
                ST_DRAIN: if (fifo_count == '0) state_next = ST_DONE;
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Push/pop decisions. A word that lands together with flush is still
    // taken because flush only moves the FSM at the end of the cycle. A pop
    // in the same cycle frees a slot, so a push into a full FIFO succeeds.
    always_comb begin
        word_accept   = (state == ST_RUN) && dma_p0_writes_en && !start;
        stray_word    = (state != ST_RUN) && dma_p0_writes_en && !start;
        line_complete = word_accept && (lane_idx == LAST_LANE);
        partial_push  = (state == ST_FLUSH) && (lane_idx != '0) && !start;
        push_req      = line_complete || partial_push;
        pop           = wr_cmd_valid && wr_cmd_ready;
        fifo_full     = (fifo_count == FULL_COUNT);
        push_ok       = push_req && (!fifo_full || pop);
        push_drop     = push_req && fifo_full && !pop;
    end

    // Line image as it would be written this cycle: the completing word is
    // merged into its lane so a full line can be pushed without an extra
    // cycle. For a partial line the mask covers lanes below lane_idx.
    always_comb begin
        line_data = pack_lanes;
        if (word_accept) begin
            line_data[lane_idx] = dma_p0_ib_data;
        end
        line_mask = '0;
        for (int k = 0; k < BURST_LEN; k++) begin
            line_mask[k] = line_complete || (k < int'(lane_idx));
        end
    end

    // Packer, address sequencer and status counters. Lanes are zeroed on
    // every push (kept or dropped) so unfilled lanes of a partial line read
    // as zero. The address only advances when the line actually entered
    // the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_lanes <= '0;
            lane_idx   <= '0;
            cur_addr   <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else if (start) begin
            pack_lanes <= '0;
            lane_idx   <= '0;
            cur_addr   <= base_addr;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (word_accept) begin
                word_count <= word_count + 32'd1;
            end
            if (push_req) begin
                pack_lanes <= '0;
                lane_idx   <= '0;
            end else if (word_accept) begin
                pack_lanes[lane_idx] <= dma_p0_ib_data;
                lane_idx             <= lane_idx + LANE_W'(1);
            end
            if (push_ok) begin
                cur_addr <= cur_addr + LINE_BYTES;
            end
            if (push_drop || stray_word) begin
                overflow <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy. start empties the FIFO, discarding
    // commands that were never accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage. Not reset; the command outputs are gated by valid so
    // stale entries never show.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_addr[wr_ptr] <= cur_addr;
            fifo_data[wr_ptr] <= line_data;
            fifo_mask[wr_ptr] <= line_mask;
        end
    end

    // Command outputs come straight from the FIFO head, so they are held
    // stable for as long as the head is not popped.
    assign wr_cmd_valid = (fifo_count != '0);

    always_comb begin
        wr_cmd_addr = '0;
        wr_cmd_data = '0;
        wr_cmd_mask = '0;
        if (wr_cmd_valid) begin
            wr_cmd_addr = fifo_addr[rd_ptr];
            wr_cmd_data = fifo_data[rd_ptr];
            wr_cmd_mask = fifo_mask[rd_ptr];
        end
    end

    assign busy       = (state != ST_IDLE);
    assign flush_done = (state == ST_DONE);

endmodule

// File: tb/tb_dma_p0_packer.sv
// ---------------------------------------------------------------------------
// tb_dma_p0_packer
//
// Self-checking bench for dma_p0_packer. The stimulus tasks keep a small
// model of the packer (lanes, lane index, address, FIFO occupancy) and push
// every command they expect onto a scoreboard queue; a monitor compares the
// FIFO head against the queue front on every cycle it is presented and pops
// on each accepted transfer.
// ---------------------------------------------------------------------------
module tb_dma_p0_packer;

    localparam int BL    = 8;
    localparam int AW    = 30;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [BL*16-1:0] data;
        logic [BL-1:0]   mask;
    } cmd_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    base_addr = '0;
    logic             dma_p0_writes_en = 1'b0;
    logic [15:0]      dma_p0_ib_data = '0;
    logic             flush = 1'b0;
    logic             wr_cmd_valid;
    logic             wr_cmd_ready = 1'b0;
    logic [AW-1:0]    wr_cmd_addr;
    logic [BL*16-1:0] wr_cmd_data;
    logic [BL-1:0]    wr_cmd_mask;
    logic             busy;
    logic             flush_done;
    logic             overflow;
    logic [31:0]      word_count;

    int total = 0;
    int bad = 0;
    int n_cmds = 0;

    // Scoreboard and packer model
    cmd_t        exp_q[$];
    logic [15:0] m_lanes [BL];
    int          m_idx = 0;
    logic [AW-1:0] m_addr = '0;
    logic [31:0] m_wc = '0;
    logic        m_ovf = 1'b0;
    logic        m_run = 1'b0;

    always #5 clk = ~clk;

    dma_p0_packer #(
        .BURST_LEN(BL),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .base_addr       (base_addr),
        .dma_p0_writes_en(dma_p0_writes_en),
        .dma_p0_ib_data  (dma_p0_ib_data),
        .flush           (flush),
        .wr_cmd_valid    (wr_cmd_valid),
        .wr_cmd_ready    (wr_cmd_ready),
        .wr_cmd_addr     (wr_cmd_addr),
        .wr_cmd_data     (wr_cmd_data),
        .wr_cmd_mask     (wr_cmd_mask),
        .busy            (busy),
        .flush_done      (flush_done),
        .overflow        (overflow),
        .word_count      (word_count)
    );

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor: inputs change #1 after posedge, so the negedge value of
    // valid & ready is exactly what the next posedge will act on.
    always @(negedge clk) begin
        if (rst_n && wr_cmd_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("cmd_unexpected", 128'(wr_cmd_valid), 128'(0));
            end else begin
                checkOutput("cmd_addr", 128'(wr_cmd_addr), 128'(exp_q[0].addr));
                checkOutput("cmd_data", 128'(wr_cmd_data), 128'(exp_q[0].data));
                checkOutput("cmd_mask", 128'(wr_cmd_mask), 128'(exp_q[0].mask));
                if (wr_cmd_ready) begin
                    void'(exp_q.pop_front());
                    n_cmds++;
                end
            end
        end
    end

    task automatic clearModel();
        for (int k = 0; k < BL; k++) m_lanes[k] = '0;
        m_idx = 0;
    endtask

    // Model of a line push at the current cycle: full FIFO without a
    // simultaneous pop drops the line and flags overflow.
    task automatic pushLine(input logic [BL-1:0] mask);
        cmd_t c;
        logic full;
        logic pop_now;
        full    = (exp_q.size() >= DEPTH);
        pop_now = wr_cmd_ready && (exp_q.size() > 0);
        if (full && !pop_now) begin
            m_ovf = 1'b1;
        end else begin
            c.addr = m_addr;
            for (int k = 0; k < BL; k++) c.data[16*k +: 16] = m_lanes[k];
            c.mask = mask;
            exp_q.push_back(c);
            m_addr = m_addr + AW'(2 * BL);
        end
        clearModel();
    endtask

    task automatic modelWord(input logic [15:0] w);
        if (!m_run) begin
            m_ovf = 1'b1;
        end else begin
            m_lanes[m_idx] = w;
            m_idx++;
            m_wc++;
            if (m_idx == BL) pushLine({BL{1'b1}});
        end
    endtask

    // All tasks start and end at posedge+1.
    task automatic applyStimulus(input logic [15:0] w);
        dma_p0_writes_en = 1'b1;
        dma_p0_ib_data   = w;
        modelWord(w);
        @(posedge clk); #1;
        dma_p0_writes_en = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic startLayer(input logic [AW-1:0] base);
        start     = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.delete();
        clearModel();
        m_addr = base;
        m_wc   = '0;
        m_ovf  = 1'b0;
        m_run  = 1'b1;
    endtask

    // Flush, optionally with a word in the same cycle, then wait (bounded)
    // for flush_done. check_timing expects an empty FIFO and ready=1.
    task automatic flushLayer(input logic check_timing, input logic with_word,
                              input logic [15:0] w);
        int done_cyc;
        logic [BL-1:0] pm;
        done_cyc = 0;
        flush = 1'b1;
        if (with_word) begin
            dma_p0_writes_en = 1'b1;
            dma_p0_ib_data   = w;
            modelWord(w);
        end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                flush = 1'b0;
                dma_p0_writes_en = 1'b0;
                m_run = 1'b0;
                if (m_idx != 0) begin
                    pm = '0;
                    for (int k = 0; k < m_idx; k++) pm[k] = 1'b1;
                    pushLine(pm);
                end
            end
            if (cyc == 2 && check_timing) begin
                checkOutput("flush_valid_t2", 128'(wr_cmd_valid), 128'(1));
            end
            if (flush_done) begin
                done_cyc = cyc;
                break;
            end
        end
        checkOutput("flush_done_seen", 128'(done_cyc != 0), 128'(1));
        if (done_cyc != 0) begin
            if (check_timing) begin
                checkOutput("flush_done_by_t4", 128'(done_cyc <= 4), 128'(1));
            end
            checkOutput("busy_in_done", 128'(busy), 128'(1));
            @(posedge clk); #1;
            checkOutput("flush_done_pulse", 128'(flush_done), 128'(0));
            checkOutput("busy_after_done", 128'(busy), 128'(0));
        end
        checkOutput("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, "_word_count"}, 128'(word_count), 128'(m_wc));
        checkOutput({tag, "_overflow"}, 128'(overflow), 128'(m_ovf));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cmds0;
        clearModel();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 128'(wr_cmd_valid), 128'(0));
        checkOutput("rst_addr", 128'(wr_cmd_addr), 128'(0));
        checkOutput("rst_data", 128'(wr_cmd_data), 128'(0));
        checkOutput("rst_mask", 128'(wr_cmd_mask), 128'(0));
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_flush_done", 128'(flush_done), 128'(0));
        checkStatus("rst");
        rst_n = 1'b1;
        idleCycles(2);

        // Word while idle is a protocol error
        applyStimulus(16'hDEAD);
        idleCycles(1);
        checkStatus("idle_word");
        checkOutput("idle_word_valid", 128'(wr_cmd_valid), 128'(0));
        checkOutput("idle_busy", 128'(busy), 128'(0));

        // Full lines, then a partial line flushed with a same-cycle word
        wr_cmd_ready = 1'b1;
        startLayer(30'h1000);
        checkStatus("start_clear");
        checkOutput("busy_after_start", 128'(busy), 128'(1));
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(16'(i));
            if (i == 8) checkOutput("line_valid_t1", 128'(wr_cmd_valid), 128'(1));
        end
        checkStatus("full_lines");
        applyStimulus(16'hAAAA);
        applyStimulus(16'hBBBB);
        flushLayer(1'b1, 1'b1, 16'hCCCC);
        checkOutput("partial_word_count", 128'(word_count), 128'(19));
        checkOutput("partial_cmds", 128'(n_cmds), 128'(3));

        // Backpressure: five lines into a four-entry FIFO
        wr_cmd_ready = 1'b0;
        startLayer(30'h4000);
        for (int i = 0; i < 40; i++) applyStimulus(16'h4000 + 16'(i));
        idleCycles(2);
        checkStatus("backpressure");
        checkOutput("bp_overflow_set", 128'(overflow), 128'(1));
        cmds0 = n_cmds;
        wr_cmd_ready = 1'b1;
        idleCycles(8);
        checkOutput("bp_cmd_count", 128'(n_cmds - cmds0), 128'(4));
        for (int i = 0; i < 8; i++) applyStimulus(16'h5000 + 16'(i));
        flushLayer(1'b0, 1'b0, 16'h0);

        // Push into a full FIFO in the same cycle as a pop
        wr_cmd_ready = 1'b0;
        startLayer(30'h2000);
        for (int i = 0; i < 39; i++) applyStimulus(16'h2000 + 16'(i));
        wr_cmd_ready = 1'b1;
        cmds0 = n_cmds;
        applyStimulus(16'h2027);
        idleCycles(8);
        checkStatus("push_pop");
        checkOutput("push_pop_overflow", 128'(overflow), 128'(0));
        checkOutput("push_pop_cmds", 128'(n_cmds - cmds0), 128'(5));
        flushLayer(1'b0, 1'b0, 16'h0);

        // Address wrap at the top of the address space
        startLayer(30'h3FFF_FFF0);
        for (int i = 0; i < 16; i++) applyStimulus(16'h7700 + 16'(i));
        flushLayer(1'b0, 1'b0, 16'h0);

        // start mid-run discards queued commands
        wr_cmd_ready = 1'b0;
        startLayer(30'h6000);
        for (int i = 0; i < 16; i++) applyStimulus(16'h6000 + 16'(i));
        idleCycles(1);
        checkOutput("restart_pre_valid", 128'(wr_cmd_valid), 128'(1));
        startLayer(30'h7000);
        checkOutput("restart_valid", 128'(wr_cmd_valid), 128'(0));
        checkStatus("restart");

        // Asynchronous reset with two queued lines
        for (int i = 0; i < 16; i++) applyStimulus(16'h8000 + 16'(i));
        idleCycles(1);
        checkOutput("mid_reset_pre_valid", 128'(wr_cmd_valid), 128'(1));
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        clearModel();
        m_run = 1'b0;
        m_wc  = '0;
        m_ovf = 1'b0;
        checkOutput("mid_reset_valid", 128'(wr_cmd_valid), 128'(0));
        checkOutput("mid_reset_addr", 128'(wr_cmd_addr), 128'(0));
        checkOutput("mid_reset_data", 128'(wr_cmd_data), 128'(0));
        checkOutput("mid_reset_mask", 128'(wr_cmd_mask), 128'(0));
        checkOutput("mid_reset_busy", 128'(busy), 128'(0));
        checkOutput("mid_reset_flush_done", 128'(flush_done), 128'(0));
        checkStatus("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr_cmd_ready = 1'b1;
        idleCycles(3);
        checkOutput("post_reset_valid", 128'(wr_cmd_valid), 128'(0));
        checkOutput("post_reset_busy", 128'(busy), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
